// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between the core memory stage and a byte-enabled,
// combinationally-read data RAM. Takes one request at a time. Turns byte,
// half and word accesses into aligned-word RAM accesses with byte enables.
// Accesses that cross a word boundary become two RAM accesses when
// MISALIGN_SPLIT=1. When MISALIGN_SPLIT=0 they are rejected with an error.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   i_req_valid         request present
//   o_req_ready         unit can accept (transfer = valid && ready)
//   i_req_we            1 = store, 0 = load
//   i_req_size          00 byte, 01 half, 10 word, 11 illegal
//   i_req_unsigned      zero-extend loads
//   i_req_addr          byte address
//   i_req_wdata         right-justified store data
//   o_rsp_valid         one-cycle response pulse
//   o_rsp_rdata         extended load data (0 for stores and errors)
//   o_rsp_err           request rejected, no RAM access made
//   o_mem_wen           RAM write enable
//   o_mem_byte_en       RAM byte enables
//   o_mem_addr          word-aligned RAM address
//   io_mem_data         RAM data bus, driven only while o_mem_wen=1
module mem_lsu #(
  parameter int ADDR_WIDTH     = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [31:0]           i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [31:0]           o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_mem_wen,
  output logic [3:0]            o_mem_byte_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  inout  wire  [31:0]           io_mem_data
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_lo;
  logic                  r_rsp_valid;
  logic [31:0]           r_rsp_rdata;
  logic                  r_rsp_err;

  logic                  w_xfer;
  logic [2:0]            w_req_bytes;
  logic [2:0]            w_req_span;
  logic                  w_req_err;
  logic [1:0]            w_off;
  logic [7:0]            w_mask8;
  logic                  w_split;
  logic [63:0]           w_wide;
  logic [31:0]           w_drive;
  logic [31:0]           w_be_exp;
  logic [31:0]           w_cap;
  logic [ADDR_WIDTH-1:0] w_word_addr;

  function automatic logic [3:0] byteMask(input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // raw holds the captured bytes as {second word, first word}.
  // Shifting by the offset puts the addressed byte at bit 0.
  function automatic logic [31:0] assembleLoad(input logic [63:0] raw,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [31:0] s;
    s = 32'(raw >> {off, 3'b000});
    case (size)
      2'b00:   return uns ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      2'b01:   return uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: return s;
    endcase
  endfunction

  // Request-side decode. A span above 4 bytes means the access crosses a word.
  always_comb begin
    w_req_bytes = 3'd4;
    case (i_req_size)
      2'b00:   w_req_bytes = 3'd1;
      2'b01:   w_req_bytes = 3'd2;
      default: w_req_bytes = 3'd4;
    endcase
  end

  assign w_req_span = {1'b0, i_req_addr[1:0]} + w_req_bytes;
  assign w_req_err  = (i_req_size == 2'b11) || (!MISALIGN_SPLIT && (w_req_span > 3'd4));
  assign w_xfer     = i_req_valid && o_req_ready;

  // Latched-request geometry. The upper nibble of the shifted mask holds the
  // byte enables for the second word, so a non-zero upper nibble means a split.
  assign w_off       = r_addr[1:0];
  assign w_mask8     = {4'b0000, byteMask(r_size)} << w_off;
  assign w_split     = (w_mask8[7:4] != 4'b0000);
  assign w_wide      = {32'h0, r_wdata} << {w_off, 3'b000};
  assign w_word_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    w_be_exp = 32'h0;
    for (int i = 0; i < 4; i++) begin
      w_be_exp[i*8 +: 8] = {8{o_mem_byte_en[i]}};
    end
  end

  assign w_cap = io_mem_data & w_be_exp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_req_valid) w_next = w_req_err ? RESP : ACC0;
      ACC0:    w_next = w_split ? ACC1 : RESP;
      ACC1:    w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // RAM-side outputs are gated by rst_n. An access cannot commit at the
  // edge where reset is sampled, so a reset during ACC1 drops that half.
  always_comb begin
    o_req_ready   = 1'b0;
    o_mem_wen     = 1'b0;
    o_mem_byte_en = 4'b0000;
    o_mem_addr    = '0;
    w_drive       = 32'h0;
    if (rst_n) begin
      case (r_state)
        IDLE: o_req_ready = 1'b1;
        ACC0: begin
          o_mem_wen     = r_we;
          o_mem_byte_en = w_mask8[3:0];
          o_mem_addr    = w_word_addr;
          w_drive       = w_wide[31:0];
        end
        ACC1: begin
          o_mem_wen     = r_we;
          o_mem_byte_en = w_mask8[7:4];
          o_mem_addr    = w_word_addr + ADDR_WIDTH'(4);
          w_drive       = w_wide[63:32];
        end
        default: ;
      endcase
    end
  end

  assign io_mem_data = o_mem_wen ? w_drive : 32'bz;

  // Request latch, load-byte capture and registered response. The response
  // registers are loaded on the same edge on which the FSM enters RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 32'h0;
      r_lo        <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_we       <= i_req_we;
            r_size     <= i_req_size;
            r_unsigned <= i_req_unsigned;
            r_addr     <= i_req_addr;
            r_wdata    <= i_req_wdata;
            if (w_req_err) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end
          end
        end
        ACC0: begin
          r_lo <= w_cap;
          if (!w_split) begin
            r_rsp_valid <= 1'b1;
            if (!r_we) r_rsp_rdata <= assembleLoad({32'h0, w_cap}, w_off, r_size, r_unsigned);
          end
        end
        ACC1: begin
          r_rsp_valid <= 1'b1;
          if (!r_we) r_rsp_rdata <= assembleLoad({w_cap, r_lo}, w_off, r_size, r_unsigned);
        end
        default: ;
      endcase
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed testbench for mem_lsu. It includes a small
// byte-enabled RAM that is read combinationally and written at the clock
// edge. A second instance with MISALIGN_SPLIT=0 exercises the reject path.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqValid;
  logic        reqValid2;
  logic        reqWe;
  logic [1:0]  reqSize;
  logic        reqUnsigned;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;

  logic        reqReady, rspValid, rspErr, memWen;
  logic [31:0] rspRdata, memAddr;
  logic [3:0]  memByteEn;
  wire  [31:0] memData;

  logic        reqReady2, rspValid2, rspErr2, memWen2;
  logic [31:0] rspRdata2, memAddr2;
  logic [3:0]  memByteEn2;
  wire  [31:0] memData2;

  logic [31:0] ram [0:63];
  logic [31:0] ramRd;

  int assertCount = 0;
  int failCount   = 0;

  int          nAcc;
  int          rspLat;
  logic [31:0] rspData;
  logic        rspErrSeen;
  logic        readyDuringOp;
  logic [31:0] accAddr [0:3];
  logic [3:0]  accBe   [0:3];
  logic [31:0] accData [0:3];
  logic        accWen  [0:3];

  mem_lsu #(.ADDR_WIDTH(32), .MISALIGN_SPLIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(reqValid), .o_req_ready(reqReady), .i_req_we(reqWe),
    .i_req_size(reqSize), .i_req_unsigned(reqUnsigned), .i_req_addr(reqAddr),
    .i_req_wdata(reqWdata), .o_rsp_valid(rspValid), .o_rsp_rdata(rspRdata),
    .o_rsp_err(rspErr), .o_mem_wen(memWen), .o_mem_byte_en(memByteEn),
    .o_mem_addr(memAddr), .io_mem_data(memData)
  );

  mem_lsu #(.ADDR_WIDTH(32), .MISALIGN_SPLIT(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(reqValid2), .o_req_ready(reqReady2), .i_req_we(reqWe),
    .i_req_size(reqSize), .i_req_unsigned(reqUnsigned), .i_req_addr(reqAddr),
    .i_req_wdata(reqWdata), .o_rsp_valid(rspValid2), .o_rsp_rdata(rspRdata2),
    .o_rsp_err(rspErr2), .o_mem_wen(memWen2), .o_mem_byte_en(memByteEn2),
    .o_mem_addr(memAddr2), .io_mem_data(memData2)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // The RAM drives the bus only while the unit is not writing.
  // The second instance sees a fixed pattern on its bus instead of a RAM.
  assign ramRd    = ram[memAddr[7:2]];
  assign memData  = memWen  ? 32'bz : ramRd;
  assign memData2 = memWen2 ? 32'bz : 32'h12345678;

  // The RAM commits enabled bytes at the edge that ends the access cycle.
  always @(posedge clk) begin
    if (memWen) begin
      for (int b = 0; b < 4; b++) begin
        if (memByteEn[b]) ram[memAddr[7:2]][b*8 +: 8] <= memData[b*8 +: 8];
      end
    end
  end

  // Global time bound so a stuck DUT can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single point of comparison: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Issues one request on the main instance and records each RAM access and
  // the response. Call it #1 after a rising edge, with the unit idle. It
  // returns #1 after the edge that brings the unit back to IDLE.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int waitCyc;
    reqWe = we; reqSize = size; reqUnsigned = uns; reqAddr = addr; reqWdata = wdata;
    reqValid = 1'b1;
    waitCyc = 0;
    while (!reqReady && waitCyc < 10) begin
      @(posedge clk); #1;
      waitCyc++;
    end
    @(posedge clk); #1;
    reqValid = 1'b0;
    nAcc = 0; rspLat = 0; rspData = 32'h0; rspErrSeen = 1'b0; readyDuringOp = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (reqReady) readyDuringOp = 1'b1;
      if (memWen || memByteEn != 4'b0000) begin
        if (nAcc < 4) begin
          accAddr[nAcc] = memAddr;
          accBe[nAcc]   = memByteEn;
          accData[nAcc] = memData;
          accWen[nAcc]  = memWen;
        end
        nAcc++;
      end
      if (rspValid) begin
        rspLat = c; rspData = rspRdata; rspErrSeen = rspErr;
        break;
      end
      @(posedge clk); #1;
    end
    if (rspLat == 0) checkOutput("rspTimeout", 32'd0, 32'd1);
    else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic sawRsp;
    rst_n = 1'b0; reqValid = 1'b0; reqValid2 = 1'b0; reqWe = 1'b0; reqSize = 2'b00;
    reqUnsigned = 1'b0; reqAddr = 32'h0; reqWdata = 32'h0;
    @(posedge clk); #1; @(posedge clk); #1;
    checkOutput("resetReady", {31'h0, reqReady}, 32'd0);
    checkOutput("resetRspValid", {31'h0, rspValid}, 32'd0);
    checkOutput("resetWen", {31'h0, memWen}, 32'd0);
    checkOutput("resetByteEn", {28'h0, memByteEn}, 32'd0);
    checkOutput("resetAddr", memAddr, 32'd0);
    rst_n = 1'b1; #1;
    checkOutput("readyAfterReset", {31'h0, reqReady}, 32'd1);

    // Aligned word store.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    checkOutput("swNumAcc", nAcc, 32'd1);
    checkOutput("swAddr", accAddr[0], 32'h10);
    checkOutput("swByteEn", {28'h0, accBe[0]}, 32'hF);
    checkOutput("swData", accData[0], 32'hDEADBEEF);
    checkOutput("swWen", {31'h0, accWen[0]}, 32'd1);
    checkOutput("swLatency", rspLat, 32'd2);
    checkOutput("swRdata", rspData, 32'h0);
    checkOutput("swErr", {31'h0, rspErrSeen}, 32'd0);
    checkOutput("swReadyLow", {31'h0, readyDuringOp}, 32'd0);

    // Sign/zero extension of byte and half loads.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
    checkOutput("lbRdata", rspData, 32'hFFFFFFFF);
    checkOutput("lbByteEn", {28'h0, accBe[0]}, 32'h4);
    checkOutput("lbWen", {31'h0, accWen[0]}, 32'd0);
    checkOutput("lbLatency", rspLat, 32'd2);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    checkOutput("lbuRdata", rspData, 32'h00000080);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    checkOutput("lhRdata", rspData, 32'hFFFF80FF);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    checkOutput("lhuRdata", rspData, 32'h00007F01);
    applyStimulus(1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
    checkOutput("lwUnsignedIgnored", rspData, 32'h80FF7F01);

    // Byte store into the middle of a word.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AB);
    checkOutput("sbByteEn", {28'h0, accBe[0]}, 32'h2);
    checkOutput("sbData", accData[0], 32'h0000AB00);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    checkOutput("sbReadback", rspData, 32'h1122AB44);

    // Split word load and split half store.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h44332211);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h14, 32'h88776655);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h18, 32'hCCCCCCCC);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    checkOutput("splitLwNumAcc", nAcc, 32'd2);
    checkOutput("splitLwAddr0", accAddr[0], 32'h10);
    checkOutput("splitLwBe0", {28'h0, accBe[0]}, 32'h8);
    checkOutput("splitLwAddr1", accAddr[1], 32'h14);
    checkOutput("splitLwBe1", {28'h0, accBe[1]}, 32'h7);
    checkOutput("splitLwRdata", rspData, 32'h77665544);
    checkOutput("splitLwLatency", rspLat, 32'd3);
    checkOutput("splitLwReadyLow", {31'h0, readyDuringOp}, 32'd0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h17, 32'h0000BBAA);
    checkOutput("splitShData0", accData[0], 32'hAA000000);
    checkOutput("splitShBe1", {28'h0, accBe[1]}, 32'h1);
    checkOutput("splitShData1", accData[1], 32'h000000BB);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    checkOutput("splitShLowWord", rspData, 32'hAA776655);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h18, 32'h0);
    checkOutput("splitShHighWord", rspData, 32'hCCCCCCBB);

    // Illegal size: rejected without touching the RAM.
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h10, 32'h0);
    checkOutput("illegalNumAcc", nAcc, 32'd0);
    checkOutput("illegalErr", {31'h0, rspErrSeen}, 32'd1);
    checkOutput("illegalLatency", rspLat, 32'd1);
    checkOutput("illegalRdata", rspData, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checkOutput("illegalNoWrite", rspData, 32'h44332211);

    // Reset during ACC1 of a split store: only the first half is kept.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h24, 32'h0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h28, 32'h0);
    reqWe = 1'b1; reqSize = 2'b10; reqUnsigned = 1'b0; reqAddr = 32'h26; reqWdata = 32'hA1B2C3D4;
    reqValid = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    checkOutput("midAcc0Be", {28'h0, memByteEn}, 32'hC);
    checkOutput("midAcc0Data", memData, 32'hC3D40000);
    @(posedge clk); #1;
    checkOutput("midAcc1Addr", memAddr, 32'h28);
    checkOutput("midAcc1Be", {28'h0, memByteEn}, 32'h3);
    rst_n = 1'b0; #1;
    checkOutput("midRstWenGated", {31'h0, memWen}, 32'd0);
    checkOutput("midRstReadyLow", {31'h0, reqReady}, 32'd0);
    @(posedge clk); #1;
    checkOutput("midRstNoRsp", {31'h0, rspValid}, 32'd0);
    rst_n = 1'b1; #1;
    checkOutput("midRstReadyBack", {31'h0, reqReady}, 32'd1);
    sawRsp = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (rspValid) sawRsp = 1'b1;
    end
    checkOutput("midRstNoLateRsp", {31'h0, sawRsp}, 32'd0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
    checkOutput("midRstAcc0Kept", rspData, 32'hC3D40000);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h28, 32'h0);
    checkOutput("midRstAcc1Dropped", rspData, 32'h00000000);

    // MISALIGN_SPLIT=0 instance: crossing load rejected, aligned load served.
    checkOutput("noSplitReady", {31'h0, reqReady2}, 32'd1);
    reqWe = 1'b0; reqSize = 2'b10; reqUnsigned = 1'b0; reqAddr = 32'h13; reqWdata = 32'h0;
    reqValid2 = 1'b1;
    @(posedge clk); #1;
    reqValid2 = 1'b0;
    checkOutput("noSplitRspValid", {31'h0, rspValid2}, 32'd1);
    checkOutput("noSplitErr", {31'h0, rspErr2}, 32'd1);
    checkOutput("noSplitNoAccess", {27'h0, memWen2, memByteEn2}, 32'd0);
    @(posedge clk); #1;
    reqAddr = 32'h10;
    reqValid2 = 1'b1;
    @(posedge clk); #1;
    reqValid2 = 1'b0;
    checkOutput("noSplitAlignedBe", {28'h0, memByteEn2}, 32'hF);
    @(posedge clk); #1;
    checkOutput("noSplitAlignedValid", {31'h0, rspValid2}, 32'd1);
    checkOutput("noSplitAlignedErr", {31'h0, rspErr2}, 32'd0);
    checkOutput("noSplitAlignedRdata", rspRdata2, 32'h12345678);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
